inside_set_matcher: RTL and testbench
=====================================

# inside_set_matcher

Sequential membership-search engine: the read/query side of the 16-entry data table. A writer port loads table entries. The block then answers "is key inside the table" queries over a valid/ready handshake, scanning one entry per cycle. For each query it returns hit, lowest matching index and match count. It sits beside the array writer and replaces the combinational `inside` reduction with a timing-friendly, single-comparator implementation.

## Interface
- DEPTH, 16, number of table entries (power of two, ≥2)
- WIDTH, 8, entry and key width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- wr_en  in  1  write table entry this cycle
- wr_addr  in  $clog2(DEPTH)  entry index to write
- wr_data  in  WIDTH  entry value; write also sets that entry's valid bit
- clr  in  1  clear all valid bits (contents untouched)
- q_valid  in  1  query request
- q_key  in  WIDTH  value to search for
- q_ready  out  1  engine can accept a query
- r_valid  out  1  result available
- r_ready  in  1  consumer accepts result
- r_hit  out  1  at least one valid entry equals key
- r_index  out  $clog2(DEPTH)  lowest matching index (0 on miss)
- r_count  out  $clog2(DEPTH)+1  number of valid matching entries
- busy  out  1  state != IDLE

## Operation
- Storage: DEPTH×WIDTH register array plus DEPTH valid bits. All valid bits are 0 after reset; contents are don't-care.
- Write: on wr_en, entry[wr_addr] <= wr_data and valid[wr_addr] <= 1. Writes are accepted in every state.
- clr: all valid bits <= 0. If clr and wr_en occur in the same cycle, clr wins for every entry except wr_addr; valid[wr_addr] ends at 1.
- FSM with three states.
  - IDLE: q_ready=1. When q_valid&q_ready, latch q_key, set idx=0, clear the hit/index/count accumulators, and go to SCAN.
  - SCAN: each cycle compare entry[idx] with the latched key, qualified by valid[idx].
    - On match: count++. If this is the first match, record idx and set hit.
    - idx++. On idx==DEPTH-1, go to DONE.
  - DONE: r_valid=1. r_hit, r_index and r_count are registered and stable. On r_valid&r_ready, go to IDLE.
- q_ready is 0 in SCAN and DONE. There is no bypass: the earliest next acceptance is the cycle after the handshake.
- Compare semantics: each compare uses the array contents registered before that edge. A write to entry[idx] in the same cycle that idx is scanned is not seen. A write to a not-yet-scanned entry is seen. A write to an already-scanned entry is not seen.
- A clr during SCAN affects the remaining compares only; accumulated results are kept.
- Reset at any time: state goes to IDLE, idx=0, r_hit=0, r_index=0, r_count=0, all valid bits 0.

## Timing
- Reset values: q_ready=1, r_valid=0, r_hit=0, r_index=0, r_count=0, busy=0.
- Query accepted at edge k. Scan compares happen at edges k+1 through k+DEPTH. r_valid rises after edge k+DEPTH. Latency is DEPTH+1 cycles from the acceptance edge, independent of hit position (no early exit).
- Result outputs hold stable while r_valid=1 and r_ready=0.
- If r_ready is already high when r_valid rises, the handshake completes in that cycle. q_ready is then high in the following cycle.
- r_count reaches DEPTH when all entries are valid and equal to the key; its width has no overflow.

## Test plan
- Load entry[i]=i*6 for i=0..7; entries 8..15 are invalid. Query 18 → r_hit=1, r_index=3, r_count=1, r_valid exactly DEPTH+1 cycles after acceptance.
- Same table, query 23 → r_hit=0, r_index=0, r_count=0. Query 0 → hit, index 0, count 1. Stale contents of entries 8..15 never match.
- Write 8'hAA to entries 2, 9 and 15. Query 8'hAA → r_hit=1, r_index=2, r_count=3. Fill all 16 entries with 8'h55 and query 8'h55 → r_count=16.
- Hold r_ready low for 5 cycles while in DONE → outputs stable, q_ready=0, q_valid ignored. Raise r_ready → q_ready=1 in the next cycle.
- Writes during scan, with table initially empty and key 8'h77:
  - Write 8'h77 to entry 0 in scan cycle 3 → not seen.
  - Write 8'h77 to entry 12 in scan cycle 3 → seen.
  - Expected result: hit, index 12, count 1.
- Assert rst mid-SCAN (cycle 7) → busy=0 and q_ready=1 immediately. A new query returns a miss because all valid bits are cleared. A clr in scan cycle 4 suppresses a match at entry 10.

Source files
------------

// File: rtl/inside_set_matcher.sv
`default_nettype none
// ============================================================================
// Module   : inside_set_matcher
// Purpose  : Sequential membership search over a DEPTH-entry table. Each
//            query scans one entry per cycle through a single comparator and
//            reports hit, lowest matching index and match count.
// Revision : 1.0 - initial release
// ============================================================================
module inside_set_matcher #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clr,
  input  logic             q_valid,
  input  logic [WIDTH-1:0] q_key,
  output logic             q_ready,
  output logic             r_valid,
  input  logic             r_ready,
  output logic             r_hit,
  output logic [AW-1:0]    r_index,
  output logic [CW-1:0]    r_count,
  output logic             busy
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]   valid;
  logic [WIDTH-1:0]   key;
  logic [AW-1:0]      scan_idx;
  logic               match;
  logic               accept;

  // The one comparator: current scan entry against the latched key.
  assign match  = valid[scan_idx] && (mem[scan_idx] == key);
  assign accept = q_valid && q_ready;

  // Table contents have no reset; only the valid bits define occupancy.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Valid bits: clr drops everything, a same-cycle write re-marks its entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else begin
      if (clr) begin
        valid <= '0;
      end
      if (wr_en) begin
        valid[wr_addr] <= 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_n = state;
    q_ready = 1'b0;
    r_valid = 1'b0;
    busy    = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        q_ready = 1'b1;
        if (q_valid) begin
          state_n = S_SCAN;
        end
      end
      S_SCAN: begin
        if (scan_idx == LAST_IDX) begin
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        r_valid = 1'b1;
        if (r_ready) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Scan index, latched key and result accumulators.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key      <= '0;
      scan_idx <= '0;
      r_hit    <= 1'b0;
      r_index  <= '0;
      r_count  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            key      <= q_key;
            scan_idx <= '0;
            r_hit    <= 1'b0;
            r_index  <= '0;
            r_count  <= '0;
          end
        end
        S_SCAN: begin
          if (match) begin
            r_count <= r_count + CW'(1);
            if (!r_hit) begin
              r_hit   <= 1'b1;
              r_index <= scan_idx;
            end
          end
          // Wraps to zero after the last entry, ready for the next query.
          scan_idx <= scan_idx + AW'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inside_set_matcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_inside_set_matcher
// Purpose  : Directed self-checking bench for inside_set_matcher.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inside_set_matcher;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [3:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             clr;
  logic             q_valid;
  logic [WIDTH-1:0] q_key;
  logic             q_ready;
  logic             r_valid;
  logic             r_ready;
  logic             r_hit;
  logic [3:0]       r_index;
  logic [4:0]       r_count;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  inside_set_matcher #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .clr     (clr),
    .q_valid (q_valid),
    .q_key   (q_key),
    .q_ready (q_ready),
    .r_valid (r_valid),
    .r_ready (r_ready),
    .r_hit   (r_hit),
    .r_index (r_index),
    .r_count (r_count),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock, returning at the falling edge where inputs change and outputs are sampled.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  // Returns just after the acceptance edge.
  task automatic start_q(input string tag, input logic [7:0] k);
    q_valid = 1'b1;
    q_key   = k;
    chk({tag, "_q_ready_idle"}, 32'(q_ready), 32'd1);
    step();
    q_valid = 1'b0;
    chk({tag, "_busy_scan"}, 32'(busy), 32'd1);
  endtask

  // done_steps: clocks already spent inside the scan after start_q.
  task automatic wait_res(input string tag, input int done_steps);
    repeat (DEPTH - 1 - done_steps) step();
    chk({tag, "_r_valid_early"}, 32'(r_valid), 32'd0);
    step();
    chk({tag, "_r_valid_on_time"}, 32'(r_valid), 32'd1);
  endtask

  task automatic chk_res(input string tag, input logic h, input logic [3:0] i, input logic [4:0] c);
    chk({tag, "_hit"},   32'(r_hit),   32'(h));
    chk({tag, "_index"}, 32'(r_index), 32'(i));
    chk({tag, "_count"}, 32'(r_count), 32'(c));
  endtask

  task automatic release_res(input string tag);
    r_ready = 1'b1;
    step();
    r_ready = 1'b0;
    chk({tag, "_r_valid_low"}, 32'(r_valid), 32'd0);
    chk({tag, "_q_ready_back"}, 32'(q_ready), 32'd1);
  endtask

  // Directed sequence of steps.
  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; clr = 1'b0;
    q_valid = 1'b0; q_key = '0; r_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_q_ready", 32'(q_ready), 32'd1);
    chk("rst_r_valid", 32'(r_valid), 32'd0);
    chk("rst_r_hit",   32'(r_hit),   32'd0);
    chk("rst_r_index", 32'(r_index), 32'd0);
    chk("rst_r_count", 32'(r_count), 32'd0);
    chk("rst_busy",    32'(busy),    32'd0);
    rst = 1'b0;
    step();

    // Stale data in 8..15 that would match, then invalidated.
    for (int i = 8; i < 16; i++) wr(4'(i), (i % 2 == 0) ? 8'd18 : 8'd0);
    clr = 1'b1; step(); clr = 1'b0;
    for (int i = 0; i < 8; i++) wr(4'(i), 8'(i * 6));

    // Query 18 -> index 3; then hold the result with r_ready low.
    start_q("q18", 8'd18);
    wait_res("q18", 0);
    chk_res("q18", 1'b1, 4'd3, 5'd1);
    q_valid = 1'b1; q_key = 8'd0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("hold_r_valid", 32'(r_valid), 32'd1);
      chk("hold_q_ready", 32'(q_ready), 32'd0);
      chk_res("hold", 1'b1, 4'd3, 5'd1);
    end
    q_valid = 1'b0;
    release_res("q18");

    // Query 23 -> miss, with r_ready already high when r_valid rises.
    start_q("q23", 8'd23);
    r_ready = 1'b1;
    wait_res("q23", 0);
    chk_res("q23", 1'b0, 4'd0, 5'd0);
    step();
    r_ready = 1'b0;
    chk("q23_early_ready_done", 32'(r_valid), 32'd0);
    chk("q23_q_ready_next",     32'(q_ready), 32'd1);

    // Query 0 -> index 0; invalid entries holding 0 do not add to the count.
    start_q("q0", 8'd0);
    wait_res("q0", 0);
    chk_res("q0", 1'b1, 4'd0, 5'd1);
    release_res("q0");

    // 0xAA in entries 2, 9, 15.
    wr(4'd2, 8'hAA); wr(4'd9, 8'hAA); wr(4'd15, 8'hAA);
    start_q("qAA", 8'hAA);
    wait_res("qAA", 0);
    chk_res("qAA", 1'b1, 4'd2, 5'd3);
    release_res("qAA");

    // Full table of 0x55 -> count reaches DEPTH.
    for (int i = 0; i < 16; i++) wr(4'(i), 8'h55);
    start_q("q55", 8'h55);
    wait_res("q55", 0);
    chk_res("q55", 1'b1, 4'd0, 5'd16);
    release_res("q55");

    // Writes during scan: entry 0 (already scanned) then entry 12 (ahead).
    clr = 1'b1; step(); clr = 1'b0;
    start_q("q77", 8'h77);
    step(); step();
    wr(4'd0, 8'h77);
    wr(4'd12, 8'h77);
    wait_res("q77", 4);
    chk_res("q77", 1'b1, 4'd12, 5'd1);
    release_res("q77");

    // clr and write in the same cycle: only the written entry survives.
    wr(4'd6, 8'h99);
    clr = 1'b1;
    wr(4'd3, 8'h99);
    clr = 1'b0;
    start_q("q99", 8'h99);
    wait_res("q99", 0);
    chk_res("q99", 1'b1, 4'd3, 5'd1);
    release_res("q99");

    // clr mid-scan: match at entry 1 kept, entry 10 suppressed.
    clr = 1'b1; step(); clr = 1'b0;
    wr(4'd1, 8'h44); wr(4'd10, 8'h44);
    start_q("q44", 8'h44);
    step(); step(); step();
    clr = 1'b1; step(); clr = 1'b0;
    wait_res("q44", 4);
    chk_res("q44", 1'b1, 4'd1, 5'd1);
    release_res("q44");

    // Asynchronous reset mid-scan, then the table is empty.
    wr(4'd5, 8'h33);
    start_q("q33", 8'h33);
    repeat (6) step();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy",    32'(busy),    32'd0);
    chk("mid_rst_q_ready", 32'(q_ready), 32'd1);
    chk("mid_rst_r_hit",   32'(r_hit),   32'd0);
    chk("mid_rst_r_count", 32'(r_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    start_q("q33b", 8'h33);
    wait_res("q33b", 0);
    chk_res("q33b", 1'b0, 4'd0, 5'd0);
    release_res("q33b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
